marco_initiator: RTL and testbench



---
 rtl/marco_initiator.sv | 180 ++++++++++++++++++
 tb/tb_marco_initiator.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/marco_initiator.sv
// Initiator side of the MARCO/POLO serial exchange: sends "MARCO\r\n" through a
// byte transmitter, then waits for "POLO" on the receive stream within a timeout.
module marco_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int unsigned TIMER_W        = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       busy,
  output logic       got_polo,
  output logic       timeout,
  output logic [7:0] pass_count,
  output logic [7:0] fail_count
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_ACK  = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;
  localparam logic [1:0] LISTEN    = 2'd3;

  localparam logic [2:0] LAST_BYTE  = 3'd6;
  localparam logic [1:0] LAST_MATCH = 2'd3;
  localparam logic [7:0] RESYNC_P   = 8'h50;
  // Timeout fires on the edge where the timer would reach TIMEOUT_CYCLES-1.
  localparam int unsigned LAST_TICK = TIMEOUT_CYCLES - 2;

  function automatic logic [7:0] msg_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    msg_byte = 8'h4D;
      3'd1:    msg_byte = 8'h41;
      3'd2:    msg_byte = 8'h52;
      3'd3:    msg_byte = 8'h43;
      3'd4:    msg_byte = 8'h4F;
      3'd5:    msg_byte = 8'h0D;
      default: msg_byte = 8'h0A;
    endcase
  endfunction

  function automatic logic [7:0] polo_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    polo_byte = 8'h50;
      2'd1:    polo_byte = 8'h4F;
      2'd2:    polo_byte = 8'h4C;
      default: polo_byte = 8'h4F;
    endcase
  endfunction

  logic [1:0]         state_q, state_d;
  logic [2:0]         byte_idx_q, byte_idx_d;
  logic [1:0]         match_idx_q, match_idx_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [7:0]         tx_data_d;
  logic               tx_start_d;
  logic               busy_d;
  logic               got_polo_d;
  logic               timeout_d;
  logic [7:0]         pass_count_d;
  logic [7:0]         fail_count_d;
  logic               reply_hit;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      byte_idx_q  <= 3'd0;
      match_idx_q <= 2'd0;
      timer_q     <= '0;
      tx_data     <= 8'h00;
      tx_start    <= 1'b0;
      busy        <= 1'b0;
      got_polo    <= 1'b0;
      timeout     <= 1'b0;
      pass_count  <= 8'h00;
      fail_count  <= 8'h00;
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      match_idx_q <= match_idx_d;
      timer_q     <= timer_d;
      tx_data     <= tx_data_d;
      tx_start    <= tx_start_d;
      busy        <= busy_d;
      got_polo    <= got_polo_d;
      timeout     <= timeout_d;
      pass_count  <= pass_count_d;
      fail_count  <= fail_count_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    match_idx_d  = match_idx_q;
    timer_d      = timer_q;
    tx_data_d    = tx_data;
    tx_start_d   = 1'b0;
    got_polo_d   = 1'b0;
    timeout_d    = 1'b0;
    pass_count_d = pass_count;
    fail_count_d = fail_count;
    reply_hit    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          tx_data_d  = msg_byte(3'd0);
          tx_start_d = 1'b1;
          byte_idx_d = 3'd0;
          state_d    = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        if (!tx_busy) begin
          if (byte_idx_q != LAST_BYTE) begin
            byte_idx_d = byte_idx_q + 3'd1;
            tx_data_d  = msg_byte(byte_idx_q + 3'd1);
            tx_start_d = 1'b1;
            state_d    = WAIT_ACK;
          end else begin
            timer_d     = '0;
            match_idx_d = 2'd0;
            state_d     = LISTEN;
          end
        end
      end

      LISTEN: begin
        timer_d = timer_q + TIMER_W'(1);
        // A stray 'P' restarts the match at index 1 so "PPOLO" still passes.
        if (rx_valid) begin
          if (rx_data == polo_byte(match_idx_q)) begin
            if (match_idx_q == LAST_MATCH) begin
              reply_hit = 1'b1;
            end else begin
              match_idx_d = match_idx_q + 2'd1;
            end
          end else if (rx_data == RESYNC_P) begin
            match_idx_d = 2'd1;
          end else begin
            match_idx_d = 2'd0;
          end
        end

        // A completed reply takes priority over a coincident timer expiry.
        if (reply_hit) begin
          got_polo_d   = 1'b1;
          pass_count_d = (pass_count == 8'hFF) ? pass_count : pass_count + 8'd1;
          match_idx_d  = 2'd0;
          state_d      = IDLE;
        end else if (timer_q == TIMER_W'(LAST_TICK)) begin
          timeout_d    = 1'b1;
          fail_count_d = (fail_count == 8'hFF) ? fail_count : fail_count + 8'd1;
          match_idx_d  = 2'd0;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_marco_initiator.sv
// Scoreboard bench for marco_initiator: a loopback byte-transmitter model, directed
// rx sequences, and a negedge monitor comparing every DUT output event to a queue.
module tb_marco_initiator;

  localparam int unsigned TO = 100;
  localparam int unsigned TW = 26;
  // Last tx_start to LISTEN entry is 5 cycles, then 99 cycles to the timeout pulse.
  localparam int TX_TO_TIMEOUT = 104;

  typedef enum int {EV_TX, EV_POLO, EV_TIMEOUT} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
    logic [7:0] pass;
    logic [7:0] fail;
    int         delta;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_start;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       got_polo;
  logic       timeout;
  logic [7:0] pass_count;
  logic [7:0] fail_count;

  marco_initiator #(.TIMEOUT_CYCLES(TO), .TIMER_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tx_busy(tx_busy),
    .tx_data(tx_data), .tx_start(tx_start), .rx_data(rx_data),
    .rx_valid(rx_valid), .busy(busy), .got_polo(got_polo),
    .timeout(timeout), .pass_count(pass_count), .fail_count(fail_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte transmitter model: busy for 3 cycles after each accepted tx_start.
  int busy_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)              busy_cnt <= 0;
    else if (tx_start)       busy_cnt <= 3;
    else if (busy_cnt > 0)   busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  ev_t        exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         last_tx_cyc = 0;
  logic [7:0] pass_m;
  logic [7:0] fail_m;
  logic [7:0] msg [0:6] = '{8'h4D, 8'h41, 8'h52, 8'h43, 8'h4F, 8'h0D, 8'h0A};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic observe(input ev_kind_t kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d data 0x%0h, expected none (cycle %0d)",
               kind, tx_data, cyc);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", int'(kind), int'(e.kind));
    if (kind != e.kind) return;
    if (kind == EV_TX) begin
      chk("tx_data", int'(tx_data), int'(e.data));
    end else begin
      chk("pass_count", int'(pass_count), int'(e.pass));
      chk("fail_count", int'(fail_count), int'(e.fail));
      if (e.delta >= 0) chk("timeout_latency", cyc - last_tx_cyc, e.delta);
    end
  endtask

  // Monitor: every output event must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_start) begin
        chk("tx_start_while_tx_busy", int'(tx_busy), 0);
        chk("busy_during_tx", int'(busy), 1);
        observe(EV_TX);
        last_tx_cyc = cyc;
      end
      if (got_polo && timeout) begin
        chk("got_polo_and_timeout", 1, 0);
      end else if (got_polo) begin
        observe(EV_POLO);
      end else if (timeout) begin
        observe(EV_TIMEOUT);
      end
    end
  end

  task automatic push_result(input ev_kind_t k);
    if (k == EV_POLO) pass_m = (pass_m == 8'hFF) ? pass_m : pass_m + 8'd1;
    else              fail_m = (fail_m == 8'hFF) ? fail_m : fail_m + 8'd1;
    exp_q.push_back('{kind: k, data: 8'h00, pass: pass_m, fail: fail_m,
                      delta: (k == EV_TIMEOUT) ? TX_TO_TIMEOUT : -1});
  endtask

  task automatic launch();
    for (int i = 0; i < 7; i++)
      exp_q.push_back('{kind: EV_TX, data: msg[i], pass: 8'h00, fail: 8'h00, delta: -1});
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_tx_byte(input logic [7:0] b, output int t0);
    t0 = -1;
    for (int i = 0; i < 100; i++) begin
      if (tx_start && tx_data == b) begin
        t0 = cyc;
        break;
      end
      @(negedge clk);
    end
    chk("tx_byte_seen", int'(t0 >= 0), 1);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk("busy_clears", int'(busy), 0);
  endtask

  task automatic send_rx(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_tx_data"}, int'(tx_data), 0);
    chk({tag, "_tx_start"}, int'(tx_start), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_got_polo"}, int'(got_polo), 0);
    chk({tag, "_timeout"}, int'(timeout), 0);
    chk({tag, "_pass_count"}, int'(pass_count), 0);
    chk({tag, "_fail_count"}, int'(fail_count), 0);
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 check_all_zero(tag);
    exp_q.delete();
    pass_m = 8'h00;
    fail_m = 8'h00;
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Full exchange answered by the given reply bytes, expected to pass.
  task automatic exchange_pass(input logic [7:0] reply [$]);
    int t0;
    launch();
    wait_tx_byte(8'h0A, t0);
    repeat (6) @(negedge clk);
    push_result(EV_POLO);
    foreach (reply[i]) send_rx(reply[i], (i == reply.size() - 1) ? 1 : 4);
    chk("got_polo_pulse", int'(got_polo), 1);
    chk("busy_after_polo", int'(busy), 0);
    @(negedge clk);
    chk("got_polo_one_cycle", int'(got_polo), 0);
  endtask

  initial begin
    int t0;
    logic [7:0] seq [$];
    rst_n    = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    pass_m   = 8'h00;
    fail_m   = 8'h00;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Transmit sequence then a clean POLO reply
    seq = '{8'h50, 8'h4F, 8'h4C, 8'h4F};
    exchange_pass(seq);
    chk("pass_after_first", int'(pass_count), 1);
    chk("timeout_after_first", int'(timeout), 0);

    // No reply -> timeout, then POLO arriving in IDLE is ignored
    launch();
    push_result(EV_TIMEOUT);
    wait_tx_byte(8'h0A, t0);
    wait_idle(200);
    chk("fail_after_timeout", int'(fail_count), 1);
    foreach (seq[i]) send_rx(seq[i], 2);
    repeat (5) @(negedge clk);
    chk("pass_unchanged_idle_rx", int'(pass_count), 1);
    chk("busy_idle_rx", int'(busy), 0);

    // Resync on a repeated 'P', then a corrupted reply
    seq = '{8'h50, 8'h50, 8'h4F, 8'h4C, 8'h4F};
    exchange_pass(seq);
    chk("pass_after_resync", int'(pass_count), 2);
    launch();
    wait_tx_byte(8'h0A, t0);
    repeat (6) @(negedge clk);
    push_result(EV_TIMEOUT);
    seq = '{8'h50, 8'h4F, 8'h58, 8'h4C, 8'h4F};
    foreach (seq[i]) send_rx(seq[i], 4);
    wait_idle(200);
    chk("fail_after_corrupt", int'(fail_count), 2);
    chk("pass_after_corrupt", int'(pass_count), 2);

    // Final reply byte on the expiry edge: match wins
    launch();
    wait_tx_byte(8'h0A, t0);
    repeat (6) @(negedge clk);
    push_result(EV_POLO);
    send_rx(8'h50, 3);
    send_rx(8'h4F, 3);
    send_rx(8'h4C, 3);
    while (cyc < t0 + TX_TO_TIMEOUT - 1) @(negedge clk);
    send_rx(8'h4F, 1);
    chk("coincide_got_polo", int'(got_polo), 1);
    chk("coincide_timeout", int'(timeout), 0);
    chk("coincide_pass", int'(pass_count), 3);
    chk("coincide_fail", int'(fail_count), 2);
    repeat (3) @(negedge clk);

    // Saturate fail_count
    for (int n = 0; n < 256; n++) begin
      launch();
      push_result(EV_TIMEOUT);
      wait_tx_byte(8'h0A, t0);
      wait_idle(200);
    end
    chk("fail_saturated", int'(fail_count), 255);
    chk("pass_after_saturation", int'(pass_count), 3);

    // Reset in WAIT_DONE during byte index 3
    launch();
    wait_tx_byte(8'h43, t0);
    repeat (2) @(negedge clk);
    async_reset("rst_wait_done");
    launch();
    push_result(EV_TIMEOUT);
    wait_tx_byte(8'h0A, t0);
    wait_idle(200);
    chk("fail_after_rst1", int'(fail_count), 1);

    // Reset mid-LISTEN
    launch();
    wait_tx_byte(8'h0A, t0);
    repeat (20) @(negedge clk);
    async_reset("rst_listen");
    seq = '{8'h50, 8'h4F, 8'h4C, 8'h4F};
    exchange_pass(seq);
    chk("pass_after_rst2", int'(pass_count), 1);
    chk("fail_after_rst2", int'(fail_count), 0);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
